// File: rtl/seed_random_opt_card_dealer_if.sv
// Deal/generator handshake bundle between game control, the card dealer and the number generator.
// CARD_DEALER_STATS_EN adds the reject_count_o statistics signal.
interface seed_random_opt_card_dealer_if;
    logic        deal_req_i;
    logic        new_deck_i;
    logic [7:0]  next_card_i;
    logic        req_card_state_o;
    logic [5:0]  card_o;
    logic        card_valid_o;
    logic        busy_o;
    logic        deck_empty_o;
    logic [5:0]  cards_left_o;
    logic        deal_err_o;
`ifdef CARD_DEALER_STATS_EN
    logic [15:0] reject_count_o;

    modport master (
        output deal_req_i, new_deck_i, next_card_i,
        input  req_card_state_o, card_o, card_valid_o, busy_o,
               deck_empty_o, cards_left_o, deal_err_o, reject_count_o
    );
    modport slave (
        input  deal_req_i, new_deck_i, next_card_i,
        output req_card_state_o, card_o, card_valid_o, busy_o,
               deck_empty_o, cards_left_o, deal_err_o, reject_count_o
    );
`else
    modport master (
        output deal_req_i, new_deck_i, next_card_i,
        input  req_card_state_o, card_o, card_valid_o, busy_o,
               deck_empty_o, cards_left_o, deal_err_o
    );
    modport slave (
        input  deal_req_i, new_deck_i, next_card_i,
        output req_card_state_o, card_o, card_valid_o, busy_o,
               deck_empty_o, cards_left_o, deal_err_o
    );
`endif
endinterface

// File: rtl/seed_random_opt_card_dealer.sv
// Card dealer: turns generator draws into unique cards 0..51, with bounded retries and a linear-scan fallback.
// Optional CARD_DEALER_STATS_EN adds a saturating 16-bit reject counter (reject_count_o).
module seed_random_opt_card_dealer #(
    parameter int unsigned HOLD_CYCLES = 3,
    parameter int unsigned MAX_RETRY   = 8
) (
    input  logic                         clk_cd_i,
    input  logic                         rst_cd_i,
    seed_random_opt_card_dealer_if.slave dif
);
    localparam int unsigned DECK_SIZE = 52;
    localparam int unsigned CARD_W    = 6;
    localparam int unsigned HOLD_W    = 4;
    localparam int unsigned RETRY_W   = 8;
    localparam int unsigned DRAW_W    = 8;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EVAL, S_SCAN, S_DONE} state_t;

    state_t               state, state_d;
    logic [DECK_SIZE-1:0] mask, mask_d;
    logic [CARD_W-1:0]    cards_left, cards_left_d;
    logic [CARD_W-1:0]    card, card_d;
    logic [CARD_W-1:0]    scan_idx, scan_idx_d;
    logic                 card_valid, card_valid_d;
    logic                 req, req_d;
    logic                 busy, busy_d;
    logic                 deck_empty, deck_empty_d;
    logic                 deal_err, deal_err_d;
    logic [RETRY_W-1:0]   retry, retry_d;
    logic [HOLD_W-1:0]    hold, hold_d;
    logic [DRAW_W-1:0]    draw, draw_d;
    logic                 in_range;
    logic [CARD_W-1:0]    cand;
    logic                 take;
    logic [CARD_W-1:0]    take_idx;

    // draw mod 52 by range compare and subtract
    always_comb begin
        in_range = draw < DRAW_W'(4 * DECK_SIZE);
        cand     = '0;
        if (!in_range)                           cand = '0;
        else if (draw >= DRAW_W'(3 * DECK_SIZE)) cand = CARD_W'(draw - DRAW_W'(3 * DECK_SIZE));
        else if (draw >= DRAW_W'(2 * DECK_SIZE)) cand = CARD_W'(draw - DRAW_W'(2 * DECK_SIZE));
        else if (draw >= DRAW_W'(DECK_SIZE))     cand = CARD_W'(draw - DRAW_W'(DECK_SIZE));
        else                                     cand = CARD_W'(draw);
    end

    always_ff @(posedge clk_cd_i or negedge rst_cd_i) begin
        if (!rst_cd_i) begin
            state      <= S_IDLE;
            mask       <= '0;
            cards_left <= CARD_W'(DECK_SIZE);
            card       <= '0;
            scan_idx   <= '0;
            card_valid <= 1'b0;
            req        <= 1'b0;
            busy       <= 1'b0;
            deck_empty <= 1'b0;
            deal_err   <= 1'b0;
            retry      <= '0;
            hold       <= '0;
            draw       <= '0;
        end else begin
            state      <= state_d;
            mask       <= mask_d;
            cards_left <= cards_left_d;
            card       <= card_d;
            scan_idx   <= scan_idx_d;
            card_valid <= card_valid_d;
            req        <= req_d;
            busy       <= busy_d;
            deck_empty <= deck_empty_d;
            deal_err   <= deal_err_d;
            retry      <= retry_d;
            hold       <= hold_d;
            draw       <= draw_d;
        end
    end

    always_comb begin
        state_d      = state;
        mask_d       = mask;
        cards_left_d = cards_left;
        card_d       = card;
        scan_idx_d   = scan_idx;
        card_valid_d = 1'b0;
        req_d        = 1'b0;
        deal_err_d   = 1'b0;
        retry_d      = retry;
        hold_d       = hold;
        draw_d       = draw;
        take         = 1'b0;
        take_idx     = '0;

        case (state)
            S_IDLE: begin
                if (dif.new_deck_i) begin
                    mask_d       = '0;
                    cards_left_d = CARD_W'(DECK_SIZE);
                end else if (dif.deal_req_i) begin
                    if (cards_left == '0) begin
                        deal_err_d = 1'b1;
                    end else begin
                        retry_d = '0;
                        hold_d  = '0;
                        req_d   = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                req_d  = 1'b1;
                hold_d = hold + HOLD_W'(1);
                if (hold == HOLD_W'(HOLD_CYCLES - 1)) begin
                    req_d   = 1'b0;
                    hold_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                draw_d  = dif.next_card_i;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                if (in_range && !mask[cand]) begin
                    take     = 1'b1;
                    take_idx = cand;
                end else begin
                    retry_d = retry + RETRY_W'(1);
                    if (retry + RETRY_W'(1) == RETRY_W'(MAX_RETRY)) begin
                        scan_idx_d = cand;
                        state_d    = S_SCAN;
                    end else begin
                        req_d   = 1'b1;
                        hold_d  = '0;
                        state_d = S_REQ;
                    end
                end
            end
            S_SCAN: begin
                if (!mask[scan_idx]) begin
                    take     = 1'b1;
                    take_idx = scan_idx;
                end else if (scan_idx == CARD_W'(DECK_SIZE - 1)) begin
                    scan_idx_d = '0;
                end else begin
                    scan_idx_d = scan_idx + CARD_W'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // accept a free card from either EVAL or SCAN
        if (take) begin
            mask_d[take_idx] = 1'b1;
            card_d           = take_idx;
            cards_left_d     = cards_left - CARD_W'(1);
            card_valid_d     = 1'b1;
            state_d          = S_DONE;
        end

        busy_d       = state_d != S_IDLE;
        deck_empty_d = cards_left_d == '0;
    end

`ifdef CARD_DEALER_STATS_EN
    localparam int unsigned STAT_W = 16;
    logic [STAT_W-1:0] reject_count;

    // saturating count of EVAL rejects since reset or the last new deck
    always_ff @(posedge clk_cd_i or negedge rst_cd_i) begin
        if (!rst_cd_i) begin
            reject_count <= '0;
        end else if (state == S_IDLE && dif.new_deck_i) begin
            reject_count <= '0;
        end else if (state == S_EVAL && !take && reject_count != '1) begin
            reject_count <= reject_count + STAT_W'(1);
        end
    end

    assign dif.reject_count_o = reject_count;
`endif

    assign dif.req_card_state_o = req;
    assign dif.card_o           = card;
    assign dif.card_valid_o     = card_valid;
    assign dif.busy_o           = busy;
    assign dif.deck_empty_o     = deck_empty;
    assign dif.cards_left_o     = cards_left;
    assign dif.deal_err_o       = deal_err;
endmodule

// File: tb/tb_seed_random_opt_card_dealer.sv
// Scoreboard bench for seed_random_opt_card_dealer: random generator draws against a deck-level reference model.
module tb_seed_random_opt_card_dealer;
    localparam int HOLD = 3;
    localparam int MAXR = 8;

    typedef struct {
        int is_err;
        int card;
        int left;
        int lat;
        int issue;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seed_random_opt_card_dealer_if dif ();

    seed_random_opt_card_dealer #(.HOLD_CYCLES(HOLD), .MAX_RETRY(MAXR)) dut (
        .clk_cd_i (clk),
        .rst_cd_i (rst_n),
        .dif      (dif)
    );

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sbq[$];
    int   stubq[$];
    bit   used[52];
    bit   seen[52];
    int   left = 52;
    int   rej_total = 0;
    int   req_rises = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Deck-level model: first acceptable draw wins, otherwise a wrapping scan for the first free card.
    task automatic model_deal(input int vals[MAXR], output int card, output int lat, output int rejs);
        int v;
        bit hit;
        hit = 0; v = 0; rejs = 0; card = 0; lat = 0;
        for (int k = 0; k < MAXR && !hit; k++) begin
            v = vals[k];
            if (v < 208 && !used[v % 52]) begin
                hit  = 1;
                card = v % 52;
                lat  = HOLD + 3 + k * (HOLD + 2);
            end else begin
                rejs++;
            end
        end
        if (!hit) begin
            int s;
            int n;
            s = (v < 208) ? v % 52 : 0;
            n = 0;
            while (used[(s + n) % 52]) n++;
            card = (s + n) % 52;
            lat  = (HOLD + 2) * (MAXR - 1) + HOLD + 4 + n;
        end
        used[card] = 1;
        left--;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 52; i++) used[i] = 0;
        left = 52;
        rej_total = 0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && sbq.size() != 0; i++) @(posedge clk);
        if (sbq.size() != 0) begin
            check("deal_timeout_pending", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    task automatic pulse_deal();
        @(posedge clk); #1;
        dif.deal_req_i = 1'b1;
        @(posedge clk); #1;
        dif.deal_req_i = 1'b0;
    endtask

    task automatic do_deal(input int vals[MAXR]);
        exp_t e;
        int c, l, r;
        model_deal(vals, c, l, r);
        rej_total += r;
        e.is_err = 0; e.card = c; e.left = left; e.lat = l;
        for (int k = 0; k < MAXR; k++) stubq.push_back(vals[k]);
        @(posedge clk); #1;
        e.issue = cyc;
        sbq.push_back(e);
        dif.deal_req_i = 1'b1;
        @(posedge clk); #1;
        dif.deal_req_i = 1'b0;
        wait_drain();
        stubq.delete();
`ifdef CARD_DEALER_STATS_EN
        check("reject_count", int'(dif.reject_count_o), rej_total);
`endif
    endtask

    task automatic random_deal();
        int vals[MAXR];
        for (int k = 0; k < MAXR; k++) vals[k] = int'($urandom_range(0, 255));
        do_deal(vals);
    endtask

    task automatic new_deck();
        @(posedge clk); #1;
        dif.new_deck_i = 1'b1;
        @(posedge clk); #1;
        dif.new_deck_i = 1'b0;
        model_clear();
        for (int i = 0; i < 52; i++) seen[i] = 0;
    endtask

    // Monitor: pop one expectation per card_valid_o / deal_err_o pulse.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && (dif.card_valid_o || dif.deal_err_o)) begin
            if (sbq.size() == 0) begin
                check("spurious_output", int'(dif.card_valid_o) + int'(dif.deal_err_o), 0);
            end else begin
                e = sbq.pop_front();
                check("out_is_err", int'(dif.deal_err_o), e.is_err);
                check("out_is_valid", int'(dif.card_valid_o), 1 - e.is_err);
                check("latency", cyc - e.issue, e.lat);
                if (e.is_err == 0) begin
                    check("card", int'(dif.card_o), e.card);
                    check("cards_left", int'(dif.cards_left_o), e.left);
                    check("deck_empty", int'(dif.deck_empty_o), (e.left == 0) ? 1 : 0);
                    check("busy_in_done", int'(dif.busy_o), 1);
                    seen[dif.card_o] = 1;
                end
            end
        end
    end

    // Generator stub: a fresh queued value on each draw request; also checks the request width.
    initial begin : stub
        bit prev;
        int hi_len;
        prev = 0; hi_len = 0;
        dif.next_card_i = 8'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hi_len = 0;
            end else if (dif.req_card_state_o) begin
                if (!prev) begin
                    req_rises++;
                    if (stubq.size() != 0) dif.next_card_i = 8'(stubq.pop_front());
                    else dif.next_card_i = 8'($urandom_range(0, 255));
                end
                hi_len++;
            end else if (hi_len != 0) begin
                check("req_high_cycles", hi_len, HOLD);
                hi_len = 0;
            end
            prev = dif.req_card_state_o;
        end
    end

    initial begin : stim
        int vals[MAXR];
        int rises0;
        int nseen;
        exp_t e;
        dif.deal_req_i = 1'b0;
        dif.new_deck_i = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", int'(dif.req_card_state_o), 0);
        check("rst_card", int'(dif.card_o), 0);
        check("rst_valid", int'(dif.card_valid_o), 0);
        check("rst_busy", int'(dif.busy_o), 0);
        check("rst_empty", int'(dif.deck_empty_o), 0);
        check("rst_left", int'(dif.cards_left_o), 52);
        check("rst_err", int'(dif.deal_err_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed: 60 -> card 8
        for (int k = 0; k < MAXR; k++) vals[k] = 60;
        do_deal(vals);
        check("first_card", int'(dif.card_o), 8);
        check("first_left", int'(dif.cards_left_o), 51);

        // directed: duplicate 8 then 110 -> card 6 after one reject
        vals[0] = 8;
        for (int k = 1; k < MAXR; k++) vals[k] = 110;
        do_deal(vals);
        check("second_card", int'(dif.card_o), 6);
        check("second_left", int'(dif.cards_left_o), 50);

        // fresh deck, all draws out of range -> scan from 0
        new_deck();
        check("newdeck_left", int'(dif.cards_left_o), 52);
        for (int k = 0; k < MAXR; k++) vals[k] = 250;
        do_deal(vals);
        check("scan_card", int'(dif.card_o), 0);

        // fill the deck with random draws
        while (left > 0) random_deal();
        nseen = 0;
        for (int i = 0; i < 52; i++) nseen += int'(seen[i]);
        check("distinct_cards", nseen, 52);
        check("full_empty", int'(dif.deck_empty_o), 1);
        check("full_left", int'(dif.cards_left_o), 0);

        // deal on empty deck -> error pulse, no draw request
        rises0 = req_rises;
        e.is_err = 1; e.card = 0; e.left = 0; e.lat = 1;
        @(posedge clk); #1;
        e.issue = cyc;
        sbq.push_back(e);
        dif.deal_req_i = 1'b1;
        @(posedge clk); #1;
        dif.deal_req_i = 1'b0;
        wait_drain();
        repeat (4) @(posedge clk);
        check("empty_no_req", req_rises - rises0, 0);

        new_deck();
        check("refill_left", int'(dif.cards_left_o), 52);
        check("refill_empty", int'(dif.deck_empty_o), 0);

        // simultaneous new_deck and deal_req: clear wins, no deal
        random_deal();
        rises0 = req_rises;
        @(posedge clk); #1;
        dif.new_deck_i = 1'b1;
        dif.deal_req_i = 1'b1;
        @(posedge clk); #1;
        dif.new_deck_i = 1'b0;
        dif.deal_req_i = 1'b0;
        model_clear();
        check("both_busy", int'(dif.busy_o), 0);
        check("both_left", int'(dif.cards_left_o), 52);
        repeat (8) @(posedge clk);
        check("both_no_req", req_rises - rises0, 0);

        // reset during REQ abandons the deal
        random_deal();
        for (int k = 0; k < MAXR; k++) stubq.push_back(int'($urandom_range(0, 255)));
        pulse_deal();
        @(posedge clk); #1;
        check("pre_rst_req", int'(dif.req_card_state_o), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_req", int'(dif.req_card_state_o), 0);
        check("midrst_left", int'(dif.cards_left_o), 52);
        check("midrst_busy", int'(dif.busy_o), 0);
        stubq.delete();
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(posedge clk);

        repeat (4) random_deal();
        check("final_left", int'(dif.cards_left_o), left);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seed_random_opt_card_dealer.md
Name: seed_random_opt_card_dealer

Overview:
- Consumer side of the card-number generator interface. Drives `req_card_state_o` into the generator's `req_card_state_dp_c_i`, samples its 8-bit `next_card_o` and maps it to a card 0..51.
- Tracks dealt cards in a 52-bit deck mask and rejects out-of-range or duplicate draws.
- Presents one unique card per user deal request. Sits between the game/control logic and the generator data path.

Parameters:
- HOLD_CYCLES, 3: cycles `req_card_state_o` stays high per draw (generator stir time), legal range 1..15.
- MAX_RETRY, 8: rejected draws tolerated per deal before falling back to the linear scan, legal range 1..255.

Ports:
- `clk_cd_i` input 1: system clock, rising edge.
- `rst_cd_i` input 1: reset, asynchronous, active-low.
- `deal_req_i` input 1: one-cycle pulse, request one card. Ignored while `busy_o`=1.
- `new_deck_i` input 1: one-cycle pulse, clear the deck mask. Ignored while `busy_o`=1.
- `next_card_i` input 8: generator value, connects to generator `next_card_o`.
- `req_card_state_o` output 1: draw request to the generator.
- `card_o` output 6: last dealt card 0..51. Holds its value until the next deal.
- `card_valid_o` output 1: one-cycle pulse when `card_o` updates.
- `busy_o` output 1: high in any state except IDLE.
- `deck_empty_o` output 1: high when all 52 cards are dealt.
- `cards_left_o` output 6: undealt count, 52..0.
- `deal_err_o` output 1: one-cycle pulse when `deal_req_i` arrives with the deck empty.

Behaviour:
- Reset (async, `rst_cd_i`=0):
  - FSM to IDLE.
  - Deck mask all 0; `cards_left_o`=52.
  - `card_o`=0, `card_valid_o`=0, `req_card_state_o`=0.
  - `busy_o`=0, `deck_empty_o`=0, `deal_err_o`=0.
  - Retry counter and hold counter = 0.
  - Reset mid-deal abandons the deal with no `card_valid_o` pulse.
- Registers: all outputs are registered; `deck_empty_o` = (`cards_left_o`==0), registered.
- FSM states: IDLE, REQ, WAIT, EVAL, SCAN, DONE.
- IDLE:
  - `new_deck_i`=1: clear mask, `cards_left_o`=52. `new_deck_i` has priority over a simultaneous `deal_req_i`, which is dropped.
  - `deal_req_i`=1 and deck empty: pulse `deal_err_o` next cycle, stay in IDLE.
  - `deal_req_i`=1 otherwise: retry=0, go to REQ.
- REQ:
  - `req_card_state_o`=1 for exactly HOLD_CYCLES cycles, then go to WAIT.
- WAIT:
  - `req_card_state_o`=0 for one cycle, so the generator output settles.
  - Capture `next_card_i` into the draw register, go to EVAL.
- EVAL (draw v):
  - v>=208: reject.
  - Otherwise candidate c = v mod 52, computed by compare/subtract (v-0, v-52, v-104, v-156). No divider.
  - mask[c]=1: reject.
  - mask[c]=0: set mask[c], `card_o`=c, decrement `cards_left_o`, go to DONE.
  - On reject: retry+1. If retry reaches MAX_RETRY, go to SCAN with index = (v mod 52 when v<208, else 0); otherwise go back to REQ.
- SCAN:
  - Tests one index per cycle. Free index: deal it as in EVAL, go to DONE. Used index: advance index, wrapping 51->0.
  - Always terminates within 52 cycles, because the deck is not empty.
- DONE:
  - `card_valid_o`=1 for one cycle, return to IDLE; `busy_o` drops the same cycle.
- Latency:
  - Best case = HOLD_CYCLES+3 cycles from `deal_req_i` to the `card_valid_o` pulse (3+3=6 at default).
  - Each reject adds HOLD_CYCLES+2 cycles.

Optional Feature:
- Macro: `CARD_DEALER_STATS_EN`.
- Defined: adds output `reject_count_o` [15:0].
  - Increments on every EVAL reject and saturates at 0xFFFF.
  - Cleared by reset and by an accepted `new_deck_i`.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then one deal with the stub generator holding `next_card_i`=60 -> `req_card_state_o` high 3 cycles; `card_valid_o` 6 cycles after `deal_req_i`; `card_o`=8, `cards_left_o`=51.
- Second deal with `next_card_i`=8, then changed to 110 after the first retry -> one reject (duplicate 8); `card_o`=6, `cards_left_o`=50; latency 11 cycles.
- `next_card_i` stuck at 250 -> 8 rejects, then SCAN from 0 -> `card_o`=0 (fresh deck). With `CARD_DEALER_STATS_EN`, `reject_count_o`=8.
- 52 deals with a free-running stub -> 52 distinct `card_o` values; `deck_empty_o`=1, `cards_left_o`=0. A 53rd `deal_req_i` -> `deal_err_o` pulse, no `req_card_state_o`.
- `new_deck_i` after the deck is empty -> `cards_left_o`=52, `deck_empty_o`=0. `new_deck_i` and `deal_req_i` asserted together -> deck cleared, no deal starts.
- `rst_cd_i` pulled low during REQ -> `req_card_state_o`=0 immediately, mask cleared, no `card_valid_o`; the next deal after reset completes normally.
